shift_stage: RTL and testbench

SHIFT_STAGE -- requirements
Module: shift_stage

---
 rtl/shift_pkg.sv | 30 +++
 rtl/shift_core.sv | 80 ++++++++
 rtl/shift_stage.sv | 118 +++++++++++
 tb/tb_shift_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared constants for the shift stage
//
// Purpose: op-code encoding, datapath width and result buffer depth shared
//          by shift_core, shift_stage and anything that drives them.
// Contents:
//   shift_op_e  - 3-bit operation code (101..111 all behave as PASS)
//   SHIFT_W     - operand/result width in bits
//   BUF_DEPTH   - entries in the in-order result buffer
//   is_right_op - helper: op shifts bits out of the low end

package shift_pkg;

  localparam int SHIFT_W   = 16;
  localparam int BUF_DEPTH = 2;

  typedef enum logic [2:0] {
    OP_ROR  = 3'b000,
    OP_ROL  = 3'b001,
    OP_LSR  = 3'b010,
    OP_LSL  = 3'b011,
    OP_ASR  = 3'b100,
    OP_PASS = 3'b101
  } shift_op_e;

  // ROR, LSR and ASR lose bits off bit 0; ROL and LSL lose them off the top.
  function automatic logic is_right_op(input logic [2:0] op);
    return (op == OP_ROR) || (op == OP_LSR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/shift_core.sv
// rtl/shift_core.sv - combinational rotate/shift datapath
//
// Purpose: computes the shifted result (and, when SHIFT_STAGE_CARRY_EN is
//          defined, the last bit shifted out) for one request.
// Optional feature macro: SHIFT_STAGE_CARRY_EN (adds the carry output).
// Ports:
//   data   in  n  operand
//   shift  in  4  shift amount 0..15
//   op     in  3  operation code (see shift_pkg)
//   result out n  shifted/rotated operand
//   carry  out 1  last bit shifted out (only with SHIFT_STAGE_CARRY_EN)

module shift_core
  import shift_pkg::*;
#(
  parameter int n = SHIFT_W
) (
  input  logic [n-1:0] data,
  input  logic [3:0]   shift,
  input  logic [2:0]   op,
`ifdef SHIFT_STAGE_CARRY_EN
  output logic         carry,
`endif
  output logic [n-1:0] result
);

  // Rotates are done by shifting a doubled copy of the operand, so the
  // wrapped bits fall out of the opposite half for free.
  logic [2*n-1:0] doubled;
  logic [2*n-1:0] rot_r_wide;
  logic [2*n-1:0] rot_l_wide;
  logic [n-1:0]   ror_res;
  logic [n-1:0]   rol_res;
  logic [n-1:0]   lsr_res;
  logic [n-1:0]   lsl_res;
  logic [n-1:0]   asr_res;

  assign doubled    = {data, data};
  assign rot_r_wide = doubled >> shift;
  assign rot_l_wide = doubled << shift;
  assign ror_res    = rot_r_wide[n-1:0];
  assign rol_res    = rot_l_wide[2*n-1:n];
  assign lsr_res    = data >> shift;
  assign lsl_res    = data << shift;
  assign asr_res    = $signed(data) >>> shift;

  always_comb begin
    result = data;
    case (op)
      OP_ROR:  result = ror_res;
      OP_ROL:  result = rol_res;
      OP_LSR:  result = lsr_res;
      OP_LSL:  result = lsl_res;
      OP_ASR:  result = asr_res;
      default: result = data;
    endcase
  end

`ifdef SHIFT_STAGE_CARRY_EN
  // Low-end ops lose operand[shift-1] last; high-end ops lose
  // operand[n-shift] last. Shift 0 and PASS lose nothing.
  logic [3:0] lo_idx;
  logic [4:0] hi_idx;

  assign lo_idx = shift - 4'd1;
  assign hi_idx = 5'(n) - {1'b0, shift};

  always_comb begin
    carry = 1'b0;
    if (shift != 4'd0) begin
      if (is_right_op(op)) begin
        carry = data[lo_idx];
      end else if ((op == OP_ROL) || (op == OP_LSL)) begin
        carry = data[hi_idx[3:0]];
      end
    end
  end
`endif

endmodule

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - shift stage with valid/ready handshake and 2-entry result buffer
//
// Purpose: accepts one shift/rotate request per cycle, computes the result
//          in the accept cycle and queues it in an in-order 2-entry buffer.
// Optional feature macro: SHIFT_STAGE_CARRY_EN (stores and presents carry;
//          otherwise out_carry is tied 0 and no carry bit is stored).
// Ports:
//   clk       in  1  clock, rising edge
//   reset     in  1  synchronous active-high reset
//   in_valid  in  1  request valid
//   in_ready  out 1  buffer has room (count < 2), independent of out_ready
//   in_data   in  n  operand
//   in_shift  in  4  shift amount
//   in_op     in  3  operation code
//   out_valid out 1  buffer holds at least one result
//   out_ready in  1  downstream takes the oldest result
//   out_data  out n  oldest result (0 when empty)
//   out_zero  out 1  oldest result equals zero
//   out_carry out 1  last bit shifted out for the oldest result

module shift_stage
  import shift_pkg::*;
#(
  parameter int n = SHIFT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_data,
  input  logic [3:0]   in_shift,
  input  logic [2:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_data,
  output logic         out_zero,
  output logic         out_carry
);

  logic [n-1:0] core_result;
  logic [n-1:0] buf_data [BUF_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

`ifdef SHIFT_STAGE_CARRY_EN
  logic core_carry;
  logic buf_carry [BUF_DEPTH];
`endif

  shift_core #(
    .n(n)
  ) u_core (
    .data   (in_data),
    .shift  (in_shift),
    .op     (in_op),
`ifdef SHIFT_STAGE_CARRY_EN
    .carry  (core_carry),
`endif
    .result (core_result)
  );

  assign in_ready  = (count < 2'(BUF_DEPTH));
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Empty buffer presents zeros so nothing stale is visible after reset
  // or after the last result drains.
  assign out_data = out_valid ? buf_data[rd_ptr] : '0;
  assign out_zero = out_valid && (buf_data[rd_ptr] == '0);

`ifdef SHIFT_STAGE_CARRY_EN
  assign out_carry = out_valid && buf_carry[rd_ptr];
`else
  assign out_carry = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data[i] <= '0;
      end
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= core_result;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef SHIFT_STAGE_CARRY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_carry[i] <= 1'b0;
      end
    end else if (push) begin
      buf_carry[wr_ptr] <= core_carry;
    end
  end
`endif

endmodule

// File: tb/tb_shift_stage.sv
// tb/tb_shift_stage.sv - self-checking bench for shift_stage
//
// Purpose: directed and random requests checked against a bit-level
//          reference model and a queue-based scoreboard.
// Optional feature macro: SHIFT_STAGE_CARRY_EN (enables carry expectations).

module tb_shift_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_shift;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic        out_carry;

  typedef struct {
    logic [15:0] data;
    logic        carry;
  } exp_t;

  exp_t expq[$];
  int   checks;
  int   errors;
  int   pops;

  shift_stage #(.n(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_carry (out_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Result bit i is taken from wherever the operation's definition says it
  // comes from; carry is the last operand bit pushed off the end.
  function automatic exp_t ref_model(input logic [2:0] op, input logic [3:0] s, input logic [15:0] d);
    exp_t e;
    int   k;
    k = int'(s);
    e.data  = d;
    e.carry = 1'b0;
    for (int i = 0; i < 16; i++) begin
      case (op)
        3'd0: e.data[i] = d[(i + k) % 16];
        3'd1: e.data[i] = d[(i - k + 16) % 16];
        3'd2: e.data[i] = (i + k < 16) ? d[i + k] : 1'b0;
        3'd3: e.data[i] = (i - k >= 0) ? d[i - k] : 1'b0;
        3'd4: e.data[i] = (i + k < 16) ? d[i + k] : d[15];
        default: e.data[i] = d[i];
      endcase
    end
`ifdef SHIFT_STAGE_CARRY_EN
    if (k != 0) begin
      if (op == 3'd0 || op == 3'd2 || op == 3'd4) e.carry = d[k - 1];
      else if (op == 3'd1 || op == 3'd3) e.carry = d[16 - k];
    end
`endif
    return e;
  endfunction

  // One clock: drive inputs, check visible state against the scoreboard,
  // then advance the scoreboard with whatever the edge transfers.
  task automatic cycle(input logic v, input logic [15:0] d, input logic [3:0] s,
                       input logic [2:0] op, input logic ordy);
    logic do_push;
    logic do_pop;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_shift  = s;
    in_op     = op;
    out_ready = ordy;
    #1;
    check("in_ready", in_ready, expq.size() < 2);
    check("out_valid", out_valid, expq.size() > 0);
    if (expq.size() > 0) begin
      check("out_data", out_data, expq[0].data);
      check("out_zero", out_zero, expq[0].data == 16'h0000);
      check("out_carry", out_carry, expq[0].carry);
    end
    do_push = v && (expq.size() < 2);
    do_pop  = ordy && (expq.size() > 0);
    @(posedge clk);
    if (do_pop) begin
      void'(expq.pop_front());
      pops++;
    end
    if (do_push) expq.push_back(ref_model(op, s, d));
  endtask

  task automatic drain();
    int budget;
    budget = 10;
    while (expq.size() > 0 && budget > 0) begin
      cycle(1'b0, 16'h0, 4'd0, 3'd0, 1'b1);
      budget--;
    end
    check("drain_timeout", expq.size(), 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pops      = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_shift  = 4'd0;
    in_op     = 3'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_carry", out_carry, 0);
    check("rst_in_ready", in_ready, 1);

    // Directed corner cases.
    cycle(1'b1, 16'h0001, 4'd1,  3'b000, 1'b1);
    cycle(1'b1, 16'h8000, 4'd15, 3'b100, 1'b1);
    cycle(1'b1, 16'h8000, 4'd15, 3'b010, 1'b1);
    cycle(1'b1, 16'h8000, 4'd1,  3'b011, 1'b1);
    cycle(1'b1, 16'hA5A5, 4'd0,  3'b000, 1'b1);
    cycle(1'b1, 16'hA5A5, 4'd7,  3'b111, 1'b1);
    cycle(1'b1, 16'h8001, 4'd4,  3'b001, 1'b1);
    drain();
    check("dir_ror_value", ref_model(3'b000, 4'd1, 16'h0001).data, 16'h8000);

    // Backpressure: third request must wait for room.
    cycle(1'b1, 16'h1234, 4'd3, 3'b000, 1'b0);
    cycle(1'b1, 16'h5678, 4'd5, 3'b011, 1'b0);
    cycle(1'b1, 16'h9ABC, 4'd2, 3'b100, 1'b0);
    check("bp_full_in_ready", in_ready, 0);
    cycle(1'b1, 16'h9ABC, 4'd2, 3'b100, 1'b0);
    cycle(1'b1, 16'h9ABC, 4'd2, 3'b100, 1'b1);
    cycle(1'b1, 16'h9ABC, 4'd2, 3'b100, 1'b1);
    drain();

    // Streaming: one result per cycle.
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 16'($urandom), 4'($urandom), 3'($urandom), 1'b1);
    end
    cycle(1'b0, 16'h0, 4'd0, 3'd0, 1'b1);
    check("stream_pops", pops, 20);
    check("stream_empty", expq.size(), 0);

    // Reset with a full buffer: nothing stale may come out.
    cycle(1'b1, 16'h1111, 4'd1, 3'b001, 1'b0);
    cycle(1'b1, 16'h2222, 4'd2, 3'b010, 1'b0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h3333;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    expq.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_in_ready", in_ready, 1);
    cycle(1'b0, 16'h0, 4'd0, 3'd0, 1'b1);
    cycle(1'b0, 16'h0, 4'd0, 3'd0, 1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom), 16'($urandom), 4'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
